id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width.
REQ-002 Parameter CNT_W, default 16, bubble-counter width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 Ctrl_ID  in  12  decoded control {RegDst,Reg_Write,ALUSrc,PcSrc,Mem_Write,Mem_to_Reg,Mem_Read,Jump,ALUOp[3:0]}, MSB first.
REQ-006 Valid_ID  in  1  ID slot holds a real instruction.
REQ-007 Rs_Data_ID / Rt_Data_ID / Imm_ID / PC4_ID  in  DATA_W each  register-file reads, sign-extended immediate, PC+4.
REQ-008 Rs_ID / Rt_ID / Rd_ID  in  5 each  register specifiers.
REQ-009 Flush  in  1  taken branch/jump resolved downstream; squash ID.
REQ-010 Hold_MEM  in  1  memory not ready; freeze this stage.
REQ-011 Ctrl_EX  out  12  registered control bundle, same field order.
REQ-012 Valid_EX  out  1  EX slot holds a real instruction.
REQ-013 Rs_Data_EX / Rt_Data_EX / Imm_EX / PC4_EX  out  DATA_W  registered copies.
REQ-014 Rs_EX / Rt_EX / Rd_EX  out  5  registered specifiers.
REQ-015 Stall  out  1  combinational; freezes PC and IF/ID register.
REQ-016 Bubble_Cnt  out  CNT_W  saturating count of inserted load-use bubbles.

Function
REQ-017 Load-use hazard (LU) SHALL be 1 when Valid_EX & Ctrl_EX.Mem_Read & Rt_EX!=0 & Valid_ID & (Rt_EX==Rs_ID | (Rt_EX==Rt_ID & (Ctrl_ID.ALUSrc==0 | Ctrl_ID.Mem_Write))).
REQ-018 Stall SHALL equal (LU & ~Flush) | Hold_MEM, same cycle, no registering.
REQ-019 Per rising edge, priority rst > Hold_MEM > Flush > LU > load; exactly one action taken.
REQ-020 Hold_MEM: all EX registers and Bubble_Cnt SHALL retain their values.
REQ-021 Flush: Ctrl_EX<=0, Valid_EX<=0; data/specifier registers are don't-care; Bubble_Cnt unchanged.
REQ-022 LU bubble: Ctrl_EX<=0, Valid_EX<=0; Bubble_Cnt increments by 1, saturating at 2^CNT_W-1.
REQ-023 Load: every EX register SHALL take its ID counterpart; if Valid_ID==0, Ctrl_EX<=0 regardless of Ctrl_ID.
REQ-024 Latency ID->EX SHALL be exactly one cycle when no hold, flush, or bubble applies.
REQ-025 An invalid EX slot (Valid_EX==0) SHALL never write registers or memory: Ctrl_EX must be all-zero whenever Valid_EX==0.
REQ-026 Specifier 0 SHALL never trigger LU, even when Rs_ID==0 or Rt_ID==0.
REQ-027 After a bubble, the stalled ID instruction SHALL load on the next non-held edge; LU then evaluates 0 since Valid_EX==0.

Reset
REQ-028 On rst at a rising edge: Ctrl_EX=0, Valid_EX=0, all data/specifier outputs=0, Bubble_Cnt=0.
REQ-029 rst SHALL override Hold_MEM and Flush; a reset mid-bubble or mid-hold leaves no residual state.
REQ-030 During rst, Stall SHALL still follow REQ-018 combinationally.

Structure
REQ-031 A shared package cpu_pkg SHALL hold the control-bundle width (12) and field bit positions, the opcode constants, and REG_ZERO=5'd0.
REQ-032 LU logic SHALL be a combinational sub-module hazard_detect; pipeline registers and counter stay in id_ex_stage.

Verification
REQ-033 LW ($8<-mem) in EX, ADD $9,$8,$10 in ID -> Stall=1, next edge Valid_EX=0, Ctrl_EX=0, Bubble_Cnt=1; following edge ADD in EX.
REQ-034 LW with Rt_EX=0 in EX, ID reads Rs_ID=0 -> Stall=0, no bubble, Bubble_Cnt unchanged.
REQ-035 LW $8 in EX, ADDI $9,$8 is not matched via Rt (ALUSrc=1, Rt_ID=8 only) -> Stall=0; same with SW Rt_ID=8 -> Stall=1.
REQ-036 Hazard present and Flush=1 same cycle -> Stall=0, Valid_EX=0, Bubble_Cnt unchanged.
REQ-037 Hold_MEM=1 for 3 cycles with Rs_Data_ID changing -> Rs_Data_EX and Ctrl_EX constant, Stall=1 throughout.
REQ-038 Bubble_Cnt preset to 16'hFFFF, another LU -> stays 16'hFFFF; assert rst -> 0 on next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: control-bundle layout, opcodes and register constants.
// Control field order is MSB first: RegDst, Reg_Write, ALUSrc, PcSrc, Mem_Write, Mem_to_Reg, Mem_Read, Jump, ALUOp.
package cpu_pkg;

  localparam int CTRL_W = 12;
  localparam int REG_W  = 5;

  localparam int CTRL_REG_DST    = 11;
  localparam int CTRL_REG_WRITE  = 10;
  localparam int CTRL_ALU_SRC    = 9;
  localparam int CTRL_PC_SRC     = 8;
  localparam int CTRL_MEM_WRITE  = 7;
  localparam int CTRL_MEM_TO_REG = 6;
  localparam int CTRL_MEM_READ   = 5;
  localparam int CTRL_JUMP       = 4;
  localparam int CTRL_ALU_OP_LSB = 0;
  localparam int ALU_OP_W        = 4;

  typedef struct packed {
    logic                reg_dst;
    logic                reg_write;
    logic                alu_src;
    logic                pc_src;
    logic                mem_write;
    logic                mem_to_reg;
    logic                mem_read;
    logic                jump;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // Typical decoded bundles, handy for stimulus and debug.
  localparam logic [CTRL_W-1:0] CTRL_ADD  = 12'hC02;
  localparam logic [CTRL_W-1:0] CTRL_ADDI = 12'h600;
  localparam logic [CTRL_W-1:0] CTRL_LW   = 12'h660;
  localparam logic [CTRL_W-1:0] CTRL_SW   = 12'h280;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination feeds a real ID instruction.
// Register zero never creates a dependency; Rt only counts when ID actually reads it as a source.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic             valid_ex,
  input  logic             mem_read_ex,
  input  logic [REG_W-1:0] rt_ex,
  input  logic             valid_id,
  input  logic             alu_src_id,
  input  logic             mem_write_id,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  output logic             load_use
);

  logic rt_is_source;

  always_comb begin
    // Stores read Rt as write data even though the ALU takes the immediate.
    rt_is_source = ~alu_src_id | mem_write_id;
    load_use     = valid_ex & mem_read_ex & (rt_ex != REG_ZERO) & valid_id &
                   ((rt_ex == rs_id) | ((rt_ex == rt_id) & rt_is_source));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating bubble counter.
// One-cycle latency; Hold_MEM freezes everything, Flush squashes, load-use inserts a bubble.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] Ctrl_ID,
  input  logic              Valid_ID,
  input  logic [DATA_W-1:0] Rs_Data_ID,
  input  logic [DATA_W-1:0] Rt_Data_ID,
  input  logic [DATA_W-1:0] Imm_ID,
  input  logic [DATA_W-1:0] PC4_ID,
  input  logic [REG_W-1:0]  Rs_ID,
  input  logic [REG_W-1:0]  Rt_ID,
  input  logic [REG_W-1:0]  Rd_ID,
  input  logic              Flush,
  input  logic              Hold_MEM,
  output logic [CTRL_W-1:0] Ctrl_EX,
  output logic              Valid_EX,
  output logic [DATA_W-1:0] Rs_Data_EX,
  output logic [DATA_W-1:0] Rt_Data_EX,
  output logic [DATA_W-1:0] Imm_EX,
  output logic [DATA_W-1:0] PC4_EX,
  output logic [REG_W-1:0]  Rs_EX,
  output logic [REG_W-1:0]  Rt_EX,
  output logic [REG_W-1:0]  Rd_EX,
  output logic              Stall,
  output logic [CNT_W-1:0]  Bubble_Cnt
);

  ctrl_t             ctrl_id;
  ctrl_t             ctrl_ex_q,    ctrl_ex_d;
  logic              valid_ex_q,   valid_ex_d;
  logic [DATA_W-1:0] rs_data_ex_q, rs_data_ex_d;
  logic [DATA_W-1:0] rt_data_ex_q, rt_data_ex_d;
  logic [DATA_W-1:0] imm_ex_q,     imm_ex_d;
  logic [DATA_W-1:0] pc4_ex_q,     pc4_ex_d;
  logic [REG_W-1:0]  rs_ex_q,      rs_ex_d;
  logic [REG_W-1:0]  rt_ex_q,      rt_ex_d;
  logic [REG_W-1:0]  rd_ex_q,      rd_ex_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic              load_use;

  assign ctrl_id = ctrl_t'(Ctrl_ID);

  hazard_detect u_hazard_detect (
    .valid_ex     (valid_ex_q),
    .mem_read_ex  (ctrl_ex_q.mem_read),
    .rt_ex        (rt_ex_q),
    .valid_id     (Valid_ID),
    .alu_src_id   (ctrl_id.alu_src),
    .mem_write_id (ctrl_id.mem_write),
    .rs_id        (Rs_ID),
    .rt_id        (Rt_ID),
    .load_use     (load_use)
  );

  // A flush kills the dependent instruction, so no stall is needed for it.
  assign Stall = (load_use & ~Flush) | Hold_MEM;

  always_comb begin
    ctrl_ex_d    = ctrl_ex_q;
    valid_ex_d   = valid_ex_q;
    rs_data_ex_d = rs_data_ex_q;
    rt_data_ex_d = rt_data_ex_q;
    imm_ex_d     = imm_ex_q;
    pc4_ex_d     = pc4_ex_q;
    rs_ex_d      = rs_ex_q;
    rt_ex_d      = rt_ex_q;
    rd_ex_d      = rd_ex_q;
    bubble_cnt_d = bubble_cnt_q;

    if (Hold_MEM) begin
      // retain everything
    end else if (Flush) begin
      ctrl_ex_d  = '0;
      valid_ex_d = 1'b0;
    end else if (load_use) begin
      ctrl_ex_d  = '0;
      valid_ex_d = 1'b0;
      if (bubble_cnt_q != {CNT_W{1'b1}}) begin
        bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      // Invalid slots carry zero control so they can never write state.
      ctrl_ex_d    = Valid_ID ? ctrl_id : '0;
      valid_ex_d   = Valid_ID;
      rs_data_ex_d = Rs_Data_ID;
      rt_data_ex_d = Rt_Data_ID;
      imm_ex_d     = Imm_ID;
      pc4_ex_d     = PC4_ID;
      rs_ex_d      = Rs_ID;
      rt_ex_d      = Rt_ID;
      rd_ex_d      = Rd_ID;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_ex_q    <= '0;
      valid_ex_q   <= 1'b0;
      rs_data_ex_q <= '0;
      rt_data_ex_q <= '0;
      imm_ex_q     <= '0;
      pc4_ex_q     <= '0;
      rs_ex_q      <= '0;
      rt_ex_q      <= '0;
      rd_ex_q      <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ctrl_ex_q    <= ctrl_ex_d;
      valid_ex_q   <= valid_ex_d;
      rs_data_ex_q <= rs_data_ex_d;
      rt_data_ex_q <= rt_data_ex_d;
      imm_ex_q     <= imm_ex_d;
      pc4_ex_q     <= pc4_ex_d;
      rs_ex_q      <= rs_ex_d;
      rt_ex_q      <= rt_ex_d;
      rd_ex_q      <= rd_ex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign Ctrl_EX    = ctrl_ex_q;
  assign Valid_EX   = valid_ex_q;
  assign Rs_Data_EX = rs_data_ex_q;
  assign Rt_Data_EX = rt_data_ex_q;
  assign Imm_EX     = imm_ex_q;
  assign PC4_EX     = pc4_ex_q;
  assign Rs_EX      = rs_ex_q;
  assign Rt_EX      = rt_ex_q;
  assign Rd_EX      = rd_ex_q;
  assign Bubble_Cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard scenarios plus random traffic against a reference model.
// A small counter width is used so counter saturation is reachable in a short run.
module tb_id_ex_stage;
  import cpu_pkg::*;

  localparam int DW      = 32;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [11:0]   Ctrl_ID = '0;
  logic          Valid_ID = 1'b0;
  logic [DW-1:0] Rs_Data_ID = '0, Rt_Data_ID = '0, Imm_ID = '0, PC4_ID = '0;
  logic [4:0]    Rs_ID = '0, Rt_ID = '0, Rd_ID = '0;
  logic          Flush = 1'b0, Hold_MEM = 1'b0;
  logic [11:0]   Ctrl_EX;
  logic          Valid_EX;
  logic [DW-1:0] Rs_Data_EX, Rt_Data_EX, Imm_EX, PC4_EX;
  logic [4:0]    Rs_EX, Rt_EX, Rd_EX;
  logic          Stall;
  logic [CW-1:0] Bubble_Cnt;

  id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .Ctrl_ID(Ctrl_ID), .Valid_ID(Valid_ID),
    .Rs_Data_ID(Rs_Data_ID), .Rt_Data_ID(Rt_Data_ID), .Imm_ID(Imm_ID), .PC4_ID(PC4_ID),
    .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Rd_ID(Rd_ID), .Flush(Flush), .Hold_MEM(Hold_MEM),
    .Ctrl_EX(Ctrl_EX), .Valid_EX(Valid_EX), .Rs_Data_EX(Rs_Data_EX), .Rt_Data_EX(Rt_Data_EX),
    .Imm_EX(Imm_EX), .PC4_EX(PC4_EX), .Rs_EX(Rs_EX), .Rt_EX(Rt_EX), .Rd_EX(Rd_EX),
    .Stall(Stall), .Bubble_Cnt(Bubble_Cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0]   ctrl;
    logic          valid;
    logic [DW-1:0] rs_data, rt_data, imm, pc4;
    logic [4:0]    rs, rt, rd;
    int            cnt;
  } ex_t;

  typedef struct {
    ex_t  st;
    logic stall;
    bit   data_known;
  } exp_t;

  exp_t exp_q[$];
  ex_t  mdl;
  bit   mdl_known = 0;
  bit   mdl_data_known = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Monitor: one expected snapshot per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("stall", 32'(Stall), 32'(e.stall));
      chk("valid_ex", 32'(Valid_EX), 32'(e.st.valid));
      chk("ctrl_ex", 32'(Ctrl_EX), 32'(e.st.ctrl));
      chk("bubble_cnt", 32'(Bubble_Cnt), 32'(e.st.cnt));
      if (Valid_EX === 1'b0) chk("ctrl_zero_when_invalid", 32'(Ctrl_EX), 32'd0);
      if (e.data_known) begin
        chk("rs_data_ex", Rs_Data_EX, e.st.rs_data);
        chk("rt_data_ex", Rt_Data_EX, e.st.rt_data);
        chk("imm_ex", Imm_EX, e.st.imm);
        chk("pc4_ex", PC4_EX, e.st.pc4);
        chk("rs_ex", 32'(Rs_EX), 32'(e.st.rs));
        chk("rt_ex", 32'(Rt_EX), 32'(e.st.rt));
        chk("rd_ex", 32'(Rd_EX), 32'(e.st.rd));
      end
    end
  end

  // Drive one cycle of ID-side inputs, record the expectation, advance the model past the edge.
  task automatic step(input logic r, input logic h, input logic f, input logic v,
                      input logic [11:0] c, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd);
    logic lu;
    exp_t e;
    ex_t  nxt;
    bit   nxt_known;
    rst = r; Hold_MEM = h; Flush = f; Valid_ID = v; Ctrl_ID = c;
    Rs_ID = rs; Rt_ID = rt; Rd_ID = rd;
    Rs_Data_ID = $urandom; Rt_Data_ID = $urandom; Imm_ID = $urandom; PC4_ID = $urandom;

    // A load in EX writing a nonzero register that the ID instruction reads.
    lu = mdl.valid && mdl.ctrl[CTRL_MEM_READ] && (mdl.rt != 5'd0) && v &&
         ((mdl.rt == rs) || ((mdl.rt == rt) && (!c[CTRL_ALU_SRC] || c[CTRL_MEM_WRITE])));
    if (mdl_known) begin
      e.st = mdl;
      e.stall = (lu && !f) || h;
      e.data_known = mdl_data_known;
      exp_q.push_back(e);
    end

    nxt = mdl;
    nxt_known = mdl_data_known;
    if (r) begin
      nxt = '0;
      nxt_known = 1;
    end else if (h) begin
      nxt = mdl;
    end else if (f) begin
      nxt.ctrl = '0; nxt.valid = 1'b0; nxt_known = 0;
    end else if (lu) begin
      nxt.ctrl = '0; nxt.valid = 1'b0; nxt_known = 0;
      nxt.cnt = (mdl.cnt + 1 > CNT_MAX) ? CNT_MAX : mdl.cnt + 1;
    end else begin
      nxt.ctrl = v ? c : 12'd0;
      nxt.valid = v;
      nxt.rs_data = Rs_Data_ID; nxt.rt_data = Rt_Data_ID;
      nxt.imm = Imm_ID; nxt.pc4 = PC4_ID;
      nxt.rs = rs; nxt.rt = rt; nxt.rd = rd;
      nxt_known = 1;
    end

    @(posedge clk);
    #1;
    if (r) mdl_known = 1;
    mdl = nxt;
    mdl_data_known = nxt_known;
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd8;
      2: return 5'd9;
      default: return 5'($urandom_range(1, 31));
    endcase
  endfunction

  function automatic logic [11:0] pick_ctrl();
    case ($urandom_range(0, 4))
      0: return CTRL_LW;
      1: return CTRL_ADD;
      2: return CTRL_ADDI;
      3: return CTRL_SW;
      default: return 12'($urandom);
    endcase
  endfunction

  initial begin
    mdl = '0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 12'd0, 0, 0, 0);
    step(1, 0, 0, 1, CTRL_ADD, 1, 2, 3);

    // LW $8 then dependent ADD $9,$8,$10: bubble, then ADD enters EX
    step(0, 0, 0, 1, CTRL_LW, 1, 8, 0);
    step(0, 0, 0, 1, CTRL_ADD, 8, 10, 9);
    step(0, 0, 0, 1, CTRL_ADD, 8, 10, 9);
    step(0, 0, 0, 1, CTRL_ADD, 3, 4, 5);

    // Load into $0 never creates a dependency
    step(0, 0, 0, 1, CTRL_LW, 1, 0, 0);
    step(0, 0, 0, 1, CTRL_ADD, 0, 0, 7);

    // ADDI only matched through Rs; SW matched through Rt
    step(0, 0, 0, 1, CTRL_LW, 1, 8, 0);
    step(0, 0, 0, 1, CTRL_ADDI, 1, 8, 0);
    step(0, 0, 0, 1, CTRL_LW, 1, 8, 0);
    step(0, 0, 0, 1, CTRL_SW, 1, 8, 0);
    step(0, 0, 0, 1, CTRL_SW, 1, 8, 0);

    // Hazard coinciding with a flush
    step(0, 0, 0, 1, CTRL_LW, 1, 8, 0);
    step(0, 0, 1, 1, CTRL_ADD, 8, 10, 9);
    step(0, 0, 0, 1, CTRL_ADD, 2, 3, 4);

    // Three held cycles with changing ID data, then release
    step(0, 0, 0, 1, CTRL_LW, 1, 8, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, CTRL_ADD, 8, 10, 9);
    step(0, 0, 0, 1, CTRL_ADD, 2, 3, 4);

    // Reset mid-hold and mid-bubble
    step(0, 0, 0, 1, CTRL_LW, 1, 8, 0);
    step(1, 1, 1, 1, CTRL_ADD, 8, 10, 9);
    step(0, 0, 0, 1, CTRL_LW, 1, 8, 0);
    step(0, 0, 0, 1, CTRL_ADD, 8, 10, 9);
    step(1, 0, 0, 1, CTRL_ADD, 8, 10, 9);

    // Self-dependent load repeated: bubble every other cycle until the counter saturates
    for (int i = 0; i < 2 * (CNT_MAX + 4); i++) step(0, 0, 0, 1, CTRL_LW, 8, 8, 0);
    step(1, 0, 0, 1, CTRL_LW, 8, 8, 0);
    step(0, 0, 0, 0, 12'd0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 85),
           pick_ctrl(), pick_reg(), pick_reg(), pick_reg());
    end

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
